sum_seq: RTL and testbench
==========================

Name: sum_seq

Overview:
Multi-cycle, parametrised adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock, with the carry passed from chunk to chunk.
- Successor to the 4-bit combinational ripple adder. Trades latency for area on wide datapaths.
- Adds subtract mode, signed-overflow and zero flags, and a start/done handshake.
- Used by ALU and datapath blocks that can tolerate multi-cycle arithmetic.

Parameters:
- WIDTH, 16, total operand/result width in bits.
- CHUNK, 4, bits summed per clock. Must divide WIDTH; elaboration fails otherwise.
- NCHUNK, WIDTH/CHUNK, derived local parameter. Cycles spent in RUN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  0: S=A+B+c_in; 1: S=A-B-c_in.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry-in (add) / borrow-in (sub), sampled on accept.
- ready  output  1  block idle; can accept start.
- done  output  1  one-cycle pulse; S and flags valid.
- S  output  WIDTH  result, held until the next accepted start.
- c_out  output  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  S == 0.

Behaviour:
Reset:
- Any clock edge with rst_n=0 forces state IDLE.
- Reset values: ready=1, done=0, S=0, c_out=0, ovf=0, zero=1.
- Internal operand registers, chunk counter and carry are cleared.
- Reset applies equally in the middle of an operation. The partial result is discarded and no done pulse is issued.

States:
- IDLE: ready=1. On start=1, latch A, B_eff = sub ? ~B : B, and carry = sub ? ~c_in : c_in. Clear chunk index k=0, then go to RUN. The S register is not cleared on accept.
- RUN: ready=0. Each cycle:
  - Compute chunk k as A[k] + B_eff[k] + carry (CHUNK-bit slice).
  - Write the chunk into the result register and update carry.
  - Increment k.
  - When k == NCHUNK-1 is processed: capture c_out, compute ovf from the MSB-stage carries, and go to DONE.
- DONE: done=1 for exactly one cycle, ready=0. S, c_out, ovf and zero are final. Next state is IDLE.

Latency and throughput:
- Start accepted at edge t gives done=1 during the cycle after edge t+NCHUNK.
- Next accept is possible at edge t+NCHUNK+2. Throughput is one operation per NCHUNK+2 cycles.

Output stability:
- S, c_out, ovf and zero update only while in RUN. Internally, the committed S is written into a separate working register; its visible outputs change only on entry to DONE.
- From DONE until the next operation's DONE, these outputs are stable.

Handshake and boundary cases:
- start while ready=0 (RUN or DONE) is ignored and not queued.
- A, B, sub and c_in may change freely after accept.
- Carry chains fully across chunk boundaries. For example, 0xFFFF+1 ripples through all chunks.
- CHUNK == WIDTH is legal: NCHUNK=1, one RUN cycle.

Optional Feature:
SUM_SEQ_ACC_EN adds accumulate mode.
- With the macro defined: an extra input port acc (1 bit) is added.
  - When start is accepted with acc=1, the operand A is replaced by the current S register.
  - This implements S <= S ± B ± c_in.
  - S resets to 0, so the first accumulate after reset starts from 0.
- Without the macro: the port is absent and A is always the port value. Behaviour is otherwise identical.

Test Plan:
- WIDTH=8, CHUNK=2, A=0xFF, B=0x01, c_in=0, sub=0, start at edge t -> done pulse in the cycle after edge t+4; S=0x00, c_out=1, ovf=0, zero=1; ready returns 1 one cycle later.
- A=0x7F, B=0x01, sub=0 -> S=0x80, c_out=0, ovf=1, zero=0.
- A=0x05, B=0x07, c_in=0, sub=1 -> S=0xFE, c_out=0 (borrow), ovf=0. Also A=0x80, B=0x01, sub=1 -> S=0x7F, ovf=1.
- Start accepted, then start=1 with new operands held for the next 3 cycles -> only the first operation completes; exactly one done pulse; S equals the first result.
- rst_n=0 for one edge while in RUN (k=2) -> next cycle ready=1, done=0, S=0, zero=1; no done pulse follows. A subsequent add of 0x10+0x20 gives S=0x30.
- With SUM_SEQ_ACC_EN defined: reset, then three accumulate starts (acc=1) with B=0x03, sub=0 -> S=0x03, then 0x06, then 0x09. Then B=0x0A with sub=1 -> S=0xFF, c_out=0.

Source files
------------

// File: rtl/sum_seq.sv
// sum_seq: multi-cycle adder/subtractor, CHUNK bits per clock with carry rippled between chunks.
// Latency: start accepted at edge t -> done pulse in the cycle after edge t+NCHUNK; one op per NCHUNK+2 cycles.
// Backpressure: ready=0 while RUN/DONE; start is ignored (not queued) unless ready=1.
//
// Ports:
//   clk, rst_n        - clock (rising edge), synchronous active-low reset
//   start/ready       - request / idle indication; accept = start & ready
//   sub, A, B, c_in   - operation select and operands, sampled on accept
//   done              - one-cycle pulse when S and flags are final
//   S, c_out, ovf, zero - result and flags, held until the next operation's done
//
// Optional: define SUM_SEQ_ACC_EN to add input 'acc'; when accepted with acc=1
// the current S replaces operand A (S <= S +/- B +/- c_in).

module sum_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
`ifdef SUM_SEQ_ACC_EN
  input  logic             acc,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  // Reject configurations where the operand cannot be split into whole chunks.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("sum_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  // Control decoded from the state.
  logic accept;
  logic running;
  logic last;

  // Operand shift registers: the chunk being summed is always the low CHUNK bits.
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  // Working result: chunks shift in from the top so that after NCHUNK cycles
  // chunk 0 sits in the low bits. Visible outputs are copied from it only at the end.
  logic [WIDTH-1:0] work_q;

  logic [WIDTH-1:0] s_q;
  logic             c_out_q, ovf_q, zero_q;

  logic [WIDTH-1:0] a_sel;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH+CHUNK-1:0] work_cat;
  logic [WIDTH-1:0] work_nxt;
  logic             msb_carry_in;

`ifdef SUM_SEQ_ACC_EN
  assign a_sel = acc ? s_q : A;
`else
  assign a_sel = A;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    running   = 1'b0;
    last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (k_q == K_LAST) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Chunk adder
  // ---------------------------------------------------------------------
  assign a_chunk   = a_q[CHUNK-1:0];
  assign b_chunk   = b_q[CHUNK-1:0];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  assign work_cat  = {chunk_sum[CHUNK-1:0], work_q};
  assign work_nxt  = work_cat[WIDTH+CHUNK-1:CHUNK];

  // The carry into a bit position equals a ^ b ^ sum at that position; this
  // recovers the carry into the MSB without a separate narrower adder and
  // works for any CHUNK including 1.
  assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      work_q  <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else if (accept) begin
      // Subtract is A + ~B + ~borrow_in; the S register is left untouched.
      a_q     <= a_sel;
      b_q     <= sub ? ~B : B;
      carry_q <= sub ^ c_in;
      k_q     <= '0;
    end else if (running) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= chunk_sum[CHUNK];
      work_q  <= work_nxt;
      k_q     <= k_q + 1'b1;
      if (last) begin
        s_q     <= work_nxt;
        c_out_q <= chunk_sum[CHUNK];
        ovf_q   <= msb_carry_in ^ chunk_sum[CHUNK];
        zero_q  <= (work_nxt == '0);
      end
    end
  end

  assign S     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_sum_seq.sv
module tb_sum_seq;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int NC = W / CH;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SUM_SEQ_ACC_EN
  logic         acc;
`endif
  logic         ready;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_s;

  sum_seq #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (a),
    .B     (b),
    .c_in  (c_in),
`ifdef SUM_SEQ_ACC_EN
    .acc   (acc),
`endif
    .ready (ready),
    .done  (done),
    .S     (s),
    .c_out (c_out),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_v;
    logic         exp_z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation: accept, latency, held-output and result checks.
  task automatic run_op(input string nm, input logic sb, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci, input logic [W-1:0] es,
                        input logic ec, input logic ev, input logic ez);
    int cycles;
    @(negedge clk);
    sub = sb; a = av; b = bv; c_in = ci; start = 1'b1;
    @(negedge clk);
    // Operands are scrambled right after accept; the result must not care.
    start = 1'b0; a = ~av; b = ~bv; c_in = ~ci; sub = ~sb;
    cycles = 1;
    chk({nm, ".busy"}, {31'd0, ready}, 32'd0);
    chk({nm, ".held"}, {24'd0, s}, {24'd0, prev_s});
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk({nm, ".latency"}, cycles, NC + 1);
    chk({nm, ".done"}, {31'd0, done}, 32'd1);
    chk({nm, ".S"}, {24'd0, s}, {24'd0, es});
    chk({nm, ".c_out"}, {31'd0, c_out}, {31'd0, ec});
    chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, ev});
    chk({nm, ".zero"}, {31'd0, zero}, {31'd0, ez});
    @(negedge clk);
    chk({nm, ".ready_after"}, {31'd0, ready}, 32'd1);
    chk({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, ".S_stable"}, {24'd0, s}, {24'd0, es});
    prev_s = es;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_s = '0;
  endtask

  initial begin
    int dones;

    vecs[0] = '{"ff_plus_1",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"pos_ovf",     1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow",  1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"sub_ovf",     1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"add_cin",     1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"neg_ovf",     1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{"sub_bin",     1'b1, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"sub_equal",   1'b1, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{"no_carry",    1'b0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

    start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef SUM_SEQ_ACC_EN
    acc = 1'b0;
`endif
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst.ready", {31'd0, ready}, 32'd1);
    chk("rst.done",  {31'd0, done},  32'd0);
    chk("rst.S",     {24'd0, s},     32'd0);
    chk("rst.c_out", {31'd0, c_out}, 32'd0);
    chk("rst.ovf",   {31'd0, ovf},   32'd0);
    chk("rst.zero",  {31'd0, zero},  32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c_in,
             vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z);
    end

    // start held high during RUN with new operands: only the first op completes.
    @(negedge clk);
    sub = 1'b0; a = 8'h21; b = 8'h13; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h44; b = 8'h44;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ignore.dones", dones, 1);
    chk("ignore.S", {24'd0, s}, 32'h34);
    chk("ignore.ready", {31'd0, ready}, 32'd1);
    prev_s = 8'h34;

    // Reset during RUN (k=2): no done, outputs back to reset values.
    @(negedge clk);
    sub = 1'b0; a = 8'h0F; b = 8'h0F; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.ready", {31'd0, ready}, 32'd1);
    chk("midrst.done",  {31'd0, done},  32'd0);
    chk("midrst.S",     {24'd0, s},     32'd0);
    chk("midrst.zero",  {31'd0, zero},  32'd1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst.no_done", dones, 0);
    prev_s = '0;
    run_op("after_rst", 1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

`ifdef SUM_SEQ_ACC_EN
    // Accumulate: A port value must be ignored in favour of S.
    do_reset();
    acc = 1'b1;
    run_op("acc1", 1'b0, 8'h77, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("acc2", 1'b0, 8'h77, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0);
    run_op("acc3", 1'b0, 8'h77, 8'h03, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
    run_op("acc_sub", 1'b1, 8'h77, 8'h0A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    acc = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
